conv_mxi8tobf16_stream: RTL

Decodes MXINT8 blocks back into bfloat16. Each block is k int8 elements plus one E8M0 shared exponent, matching the format produced by the bf16-to-MXINT8 encoder. A block is accepted in one valid/ready handshake, held in a register, and streamed out as k/lanes beats of `lanes` bf16 values. Sits on the read-back path from MX storage into bf16 datapaths.

---
 rtl/mx_pkg.sv | 30 +++
 rtl/conv_mxi8tobf16_stream_if.sv | 39 +++
 rtl/mxi8_elem_to_bf16.sv | 42 ++++
 rtl/conv_mxi8tobf16_stream.sv | 111 +++++++++++
 4 files changed

// File: rtl/mx_pkg.sv
// Shared constants and types for the MXINT8 -> bf16 read-back path.
// Holds E8M0/bf16 encodings, the bf16 struct and the stream FSM states.
package mx_pkg;

  localparam logic [7:0]  E8M0_NAN       = 8'hFF;
  localparam int          E8M0_BIAS      = 127;
  localparam int          MXI8_FRAC_BITS = 6;
  localparam int          BF16_BIAS      = 127;
  localparam logic [15:0] BF16_QNAN      = 16'h7FC0;
  localparam logic [7:0]  BF16_EXP_MAX   = 8'hFF;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] man;
  } bf16_t;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  function automatic logic [2:0] lead_one(input logic [7:0] v);
    lead_one = '0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) lead_one = 3'(i);
    end
  endfunction

endpackage

// File: rtl/conv_mxi8tobf16_stream_if.sv
// Block-in / beat-out handshake bundle for the MXINT8 decoder.
// slv is the decoder side, mst the producer/consumer side.
interface conv_mxi8tobf16_stream_if #(
  parameter int k     = 32,
  parameter int lanes = 8
);

  logic                   i_valid;
  logic                   o_ready;
  logic [k-1:0][7:0]      i_mx_vec;
  logic [7:0]             i_mx_exp;
  logic                   o_valid;
  logic                   i_ready;
  logic [lanes-1:0][15:0] o_bf16_vec;
  logic                   o_last;

  modport slv (
    input  i_valid,
    input  i_mx_vec,
    input  i_mx_exp,
    input  i_ready,
    output o_ready,
    output o_valid,
    output o_bf16_vec,
    output o_last
  );

  modport mst (
    output i_valid,
    output i_mx_vec,
    output i_mx_exp,
    output i_ready,
    input  o_ready,
    input  o_valid,
    input  o_bf16_vec,
    input  o_last
  );

endinterface

// File: rtl/mxi8_elem_to_bf16.sv
// One int8 (1.6 fixed point) element scaled by an E8M0 exponent to bf16.
// Purely combinational; every in-range value is exact.
module mxi8_elem_to_bf16
  import mx_pkg::*;
(
  input  logic [7:0] elem,
  input  logic [7:0] scale,
  output bf16_t      bf16
);

  logic              sign;
  logic [7:0]        mag;
  logic [2:0]        p;
  logic signed [10:0] e;

  always_comb begin
    sign = elem[7];
    // 8-bit unsigned negate still yields 128 for -128
    mag  = sign ? 8'(8'd0 - elem) : elem;
    p    = lead_one(mag);
    e    = $signed({3'b000, scale})
         + $signed({8'b0, p})
         + 11'(BF16_BIAS - E8M0_BIAS - MXI8_FRAC_BITS);

    bf16 = '0;
    if (scale == E8M0_NAN) begin
      bf16 = BF16_QNAN;
    end else if (elem == 8'd0) begin
      bf16 = '0;
    end else if (e <= 11'sd0) begin
      bf16.sign = sign;
    end else if (e >= 11'sd255) begin
      bf16.sign = sign;
      bf16.exp  = BF16_EXP_MAX;
    end else begin
      bf16.sign = sign;
      bf16.exp  = e[7:0];
      bf16.man  = 7'(mag << (3'd7 - p));
    end
  end

endmodule

// File: rtl/conv_mxi8tobf16_stream.sv
// MXINT8 block decoder: accepts a block in one handshake and streams it
// out as k/lanes beats of bf16, with no bubble between blocks.
module conv_mxi8tobf16_stream
  import mx_pkg::*;
#(
  parameter int k     = 32,
  parameter int lanes = 8
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  conv_mxi8tobf16_stream_if.slv  bus
);

  localparam int NB = k / lanes;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  if ((k % lanes) != 0 || NB < 2) begin : g_param_chk
    $error("conv_mxi8tobf16_stream: k must be a multiple of lanes, k/lanes >= 2");
  end

  state_t                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [NB-1:0][lanes-1:0][7:0] blk_q;
  logic [7:0]                   exp_q;
  logic [lanes-1:0][7:0]        beat;
  logic [lanes-1:0][15:0]       conv_w;
  logic [lanes-1:0][15:0]       out_q;
  logic                         valid_q;
  logic                         last_q;
  logic                         load_en;
  logic                         is_last;
  logic                         cap;
  logic                         beat_ld;

  assign load_en = !valid_q | bus.i_ready;
  assign is_last = (cnt_q == CW'(NB - 1));

  assign bus.o_ready = i_rst_n &
    ((state_q == IDLE) | ((state_q == SEND) & is_last & load_en));

  assign bus.o_valid    = valid_q;
  assign bus.o_last     = last_q;
  assign bus.o_bf16_vec = out_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    beat_ld = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          cap     = 1'b1;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (load_en) begin
          beat_ld = 1'b1;
          if (is_last) begin
            // Last beat leaves: a waiting block slots straight in
            if (bus.i_valid) begin
              cap   = 1'b1;
              cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
    endcase
  end

  assign beat = blk_q[cnt_q];

  for (genvar j = 0; j < lanes; j++) begin : g_lane
    mxi8_elem_to_bf16 u_cvt (
      .elem  (beat[j]),
      .scale (exp_q),
      .bf16  (conv_w[j])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
      exp_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap) begin
        blk_q <= bus.i_mx_vec;
        exp_q <= bus.i_mx_exp;
      end
      if (load_en) begin
        valid_q <= beat_ld;
        last_q  <= beat_ld & is_last;
        if (beat_ld) out_q <= conv_w;
      end
    end
  end

endmodule
